// File: rtl/pipe_stage_reg.sv
// Pipeline transfer register between two CPU stages: data words, instruction and valid,
// with flush/NOP injection, EMPTY/FULL/HELD tracking, saturating perf counters and a stall watchdog.
module pipe_stage_reg #(
    parameter int                NUM_FIELDS = 4,
    parameter int                FIELD_W    = 32,
    parameter int                INST_W     = 32,
    parameter logic [INST_W-1:0] NOP_INST   = INST_W'(32'h00000013),
    parameter int                CNT_W      = 16,
    parameter int                MAX_STALL  = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          stall,
    input  logic                          flush,
    input  logic                          valid_in,
    input  logic [NUM_FIELDS*FIELD_W-1:0] fields_in,
    input  logic [INST_W-1:0]             inst_in,
    output logic                          valid_out,
    output logic [NUM_FIELDS*FIELD_W-1:0] fields_out,
    output logic [INST_W-1:0]             inst_out,
    output logic [1:0]                    state_out,
    output logic [CNT_W-1:0]              stall_run,
    output logic [CNT_W-1:0]              stall_total,
    output logic [CNT_W-1:0]              bubble_total,
    output logic                          stall_timeout
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b01,
        ST_HELD  = 2'b10
    } state_t;

    state_t state_q;
    state_t state_d;

    // Counters stick at all-ones rather than wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Every state element updates on the falling edge of clk.
    always_ff @(negedge clk) begin
        if (reset) state_q <= ST_EMPTY;
        else       state_q <= state_d;
    end

    // The unreachable encoding 2'b11 falls into default and is treated as EMPTY.
    always_comb begin
        state_d = ST_EMPTY;
        if (flush) begin
            state_d = ST_EMPTY;
        end else if (stall) begin
            case (state_q)
                ST_FULL, ST_HELD: state_d = ST_HELD;
                default:          state_d = ST_EMPTY;
            endcase
        end else begin
            state_d = valid_in ? ST_FULL : ST_EMPTY;
        end
    end

    always_comb begin
        state_out     = state_q;
        stall_timeout = (32'(stall_run) >= 32'(MAX_STALL));
    end

    // A bubble load clears the payload exactly like reset and flush do.
    always_ff @(negedge clk) begin
        if (reset || flush || (!stall && !valid_in)) begin
            valid_out  <= 1'b0;
            fields_out <= '0;
            inst_out   <= NOP_INST;
        end else if (!stall) begin
            valid_out  <= 1'b1;
            fields_out <= fields_in;
            inst_out   <= inst_in;
        end
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            stall_run    <= '0;
            stall_total  <= '0;
            bubble_total <= '0;
        end else if (flush) begin
            stall_run    <= '0;
        end else if (stall) begin
            stall_run    <= sat_inc(stall_run);
            stall_total  <= sat_inc(stall_total);
        end else begin
            stall_run    <= '0;
            if (!valid_in) bubble_total <= sat_inc(bubble_total);
        end
    end

endmodule
